// File: rtl/ps2_pkg.sv
// Shared PS/2 Set 2 byte constants, parser state encoding and the queued key-event record.
package ps2_pkg;

    localparam logic [7:0] PS2_F0 = 8'hF0;
    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_E1 = 8'hE1;
    localparam logic [7:0] PS2_AA = 8'hAA;
    localparam logic [7:0] PS2_FA = 8'hFA;
    localparam logic [7:0] PS2_EE = 8'hEE;
    localparam logic [7:0] PS2_FE = 8'hFE;
    localparam logic [7:0] PS2_00 = 8'h00;
    localparam logic [7:0] PS2_FF = 8'hFF;

    // Bytes that follow the E1 that opens the Pause/Break sequence.
    localparam logic [2:0] PAUSE_TAIL_LEN = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GOT_E0   = 3'd1,
        ST_GOT_F0   = 3'd2,
        ST_GOT_E0F0 = 3'd3,
        ST_PAUSE    = 3'd4
    } ps2_state_e;

    typedef struct packed {
        logic       extended;
        logic       released;
        logic [7:0] code;
    } ps2_event_t;

    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == PS2_FA) || (b == PS2_EE) || (b == PS2_FE);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead FIFO for completed key events; head is presented whenever not empty.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = $bits(ps2_event_t)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop frees the slot the simultaneous push needs, so a full FIFO still accepts it.
    assign push_ok = push && (!full || pop_ok);

    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ps2_scancode_controller.sv
// Turns the PS/2 Set 2 byte stream into {extended, released, code} key events queued for the host.
module ps2_scancode_controller
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       event_valid,
    output logic [7:0] event_code,
    output logic       event_extended,
    output logic       event_release,
    input  logic       event_ready,
    output logic       bat_ok,
    output logic       error,
    output logic       overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e state_q, state_d;
    logic [2:0]    pause_cnt_q, pause_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          bat_ok_q, bat_ok_d;
    logic          error_q, error_d;
    logic          overflow_q, overflow_d;

    logic          in_seq;
    logic          tmo_hit;
    logic          push;
    ps2_event_t    push_evt;
    ps2_event_t    head_evt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    assign in_seq  = (state_q != ST_IDLE);
    // The silent cycle that would make the count reach TIMEOUT_CYCLES aborts the sequence.
    assign tmo_hit = in_seq && !rx_valid && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pause_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            bat_ok_q    <= 1'b0;
            error_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pause_cnt_q <= pause_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            bat_ok_q    <= bat_ok_d;
            error_q     <= error_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pause_cnt_d = pause_cnt_q;
        tmo_cnt_d   = (in_seq && !rx_valid) ? tmo_cnt_q + 1'b1 : '0;
        if (tmo_hit) begin
            state_d   = ST_IDLE;
            tmo_cnt_d = '0;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == PS2_F0) begin
                        state_d = ST_GOT_F0;
                    end else if (rx_data == PS2_E0) begin
                        state_d = ST_GOT_E0;
                    end else if (rx_data == PS2_E1) begin
                        state_d     = ST_PAUSE;
                        pause_cnt_d = PAUSE_TAIL_LEN;
                    end
                end
                ST_GOT_E0: begin
                    if (rx_data == PS2_F0) begin
                        state_d = ST_GOT_E0F0;
                    end else if (rx_data != PS2_E0) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PAUSE: begin
                    pause_cnt_d = pause_cnt_q - 3'd1;
                    if (pause_cnt_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        push     = 1'b0;
        push_evt = '0;
        bat_ok_d = 1'b0;
        error_d  = tmo_hit;
        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == PS2_AA) begin
                        bat_ok_d = 1'b1;
                    end else if ((rx_data == PS2_00) || (rx_data == PS2_FF)) begin
                        error_d = 1'b1;
                    end else if ((rx_data != PS2_F0) && (rx_data != PS2_E0) &&
                                 (rx_data != PS2_E1) && !is_status_byte(rx_data)) begin
                        push     = 1'b1;
                        push_evt = '{extended: 1'b0, released: 1'b0, code: rx_data};
                    end
                end
                ST_GOT_E0: begin
                    if ((rx_data != PS2_F0) && (rx_data != PS2_E0)) begin
                        push     = 1'b1;
                        push_evt = '{extended: 1'b1, released: 1'b0, code: rx_data};
                    end
                end
                ST_GOT_F0: begin
                    push     = 1'b1;
                    push_evt = '{extended: 1'b0, released: 1'b1, code: rx_data};
                end
                ST_GOT_E0F0: begin
                    push     = 1'b1;
                    push_evt = '{extended: 1'b1, released: 1'b1, code: rx_data};
                end
                ST_PAUSE: begin
                    if (pause_cnt_q == 3'd1) begin
                        push     = 1'b1;
                        push_evt = '{extended: 1'b0, released: 1'b0, code: PS2_E1};
                    end
                end
                default: ;
            endcase
        end
        overflow_d = overflow_q || (push && fifo_full && !pop);
    end

    ps2_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(ps2_event_t))
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_evt),
        .pop       (pop),
        .head_data (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Handshake: the head is offered while event_valid is high; it leaves on a cycle with event_ready.
    assign event_valid    = !fifo_empty;
    assign pop            = event_valid && event_ready;
    assign event_code     = head_evt.code;
    assign event_extended = head_evt.extended;
    assign event_release  = head_evt.released;
    assign bat_ok         = bat_ok_q;
    assign error          = error_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_controller.sv
// Bench for ps2_scancode_controller: directed vectors, multi-byte corner sequences, random stream vs reference model.
module tb_ps2_scancode_controller;

    localparam int DEPTH = 8;
    localparam int TMO   = 40;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       event_valid;
    logic [7:0] event_code;
    logic       event_extended;
    logic       event_release;
    logic       event_ready;
    logic       bat_ok;
    logic       error;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    ps2_scancode_controller #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .event_valid    (event_valid),
        .event_code     (event_code),
        .event_extended (event_extended),
        .event_release  (event_release),
        .event_ready    (event_ready),
        .bat_ok         (bat_ok),
        .error          (error),
        .overflow       (overflow)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic strobe(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic pop_one();
        event_ready = 1'b1;
        @(negedge clock);
        event_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_head(input string name, input logic [7:0] code, input logic ext, input logic rel);
        chk({name, "_valid"}, 32'(event_valid), 32'd1);
        chk({name, "_code"}, 32'(event_code), 32'(code));
        chk({name, "_ext"}, 32'(event_extended), 32'(ext));
        chk({name, "_rel"}, 32'(event_release), 32'(rel));
    endtask

    // ---------------- reference model + scoreboard ----------------
    // Event queue entries are {extended, released, code}.
    logic [9:0] exp_q[$];
    logic [7:0] pfx[$];
    int         pause_left;
    int         idle_cycles;
    bit         m_bat;
    bit         m_err;
    bit         m_ovf;

    task automatic model_clear();
        exp_q.delete();
        pfx.delete();
        pause_left  = 0;
        idle_cycles = 0;
        m_bat       = 0;
        m_err       = 0;
        m_ovf       = 0;
    endtask

    // One clock edge of the reference behaviour, given the inputs present at that edge.
    task automatic model_edge(input bit rdy, input bit rxv, input logic [7:0] b);
        bit         has_e0;
        bit         has_f0;
        bit         push_v;
        logic [9:0] ev;
        has_e0 = 0;
        has_f0 = 0;
        push_v = 0;
        ev     = '0;
        m_bat  = 0;
        m_err  = 0;
        if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        foreach (pfx[i]) begin
            if (pfx[i] == 8'hE0) has_e0 = 1;
            if (pfx[i] == 8'hF0) has_f0 = 1;
        end
        if (rxv) begin
            idle_cycles = 0;
            if (pause_left > 0) begin
                pause_left--;
                if (pause_left == 0) begin
                    push_v = 1;
                    ev     = {2'b00, 8'hE1};
                end
            end else if (has_f0) begin
                push_v = 1;
                ev     = {has_e0, 1'b1, b};
                pfx.delete();
            end else if (has_e0) begin
                if (b == 8'hF0 || b == 8'hE0) pfx.push_back(b);
                else begin
                    push_v = 1;
                    ev     = {2'b10, b};
                    pfx.delete();
                end
            end else begin
                case (b)
                    8'hF0, 8'hE0:        pfx.push_back(b);
                    8'hE1:               pause_left = 7;
                    8'hAA:               m_bat = 1;
                    8'h00, 8'hFF:        m_err = 1;
                    8'hFA, 8'hEE, 8'hFE: ;
                    default: begin
                        push_v = 1;
                        ev     = {2'b00, b};
                    end
                endcase
            end
        end else if (pfx.size() > 0 || pause_left > 0) begin
            idle_cycles++;
            if (idle_cycles == TMO) begin
                pfx.delete();
                pause_left  = 0;
                idle_cycles = 0;
                m_err       = 1;
            end
        end
        if (push_v) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(ev);
            else m_ovf = 1;
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [7:0] data;
        logic       ev;
        logic       bat;
        logic       err;
    } vec_t;

    vec_t vecs[8];

    logic [7:0] pause_seq[8];
    logic [7:0] pool[12];

    initial begin
        int k;
        int gap;
        bit rdy;
        bit rxv;
        logic [7:0] b;

        reset       = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        event_ready = 1'b0;

        vecs[0] = '{8'h1C, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hAA, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'hFA, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'hEE, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'h76, 1'b1, 1'b0, 1'b0};

        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        pool      = '{8'hF0, 8'hE0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hF0, 8'hE0, 8'hF0};

        tick();
        tick();
        reset = 1'b0;
        tick();

        chk("rst_valid", 32'(event_valid), 32'd0);
        chk("rst_code", 32'(event_code), 32'd0);
        chk("rst_ext", 32'(event_extended), 32'd0);
        chk("rst_rel", 32'(event_release), 32'd0);
        chk("rst_bat", 32'(bat_ok), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        for (int i = 0; i < 8; i++) begin
            strobe(vecs[i].data);
            chk($sformatf("vec%0d_valid", i), 32'(event_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_bat", i), 32'(bat_ok), 32'(vecs[i].bat));
            chk($sformatf("vec%0d_err", i), 32'(error), 32'(vecs[i].err));
            if (vecs[i].ev) begin
                chk_head($sformatf("vec%0d", i), vecs[i].data, 1'b0, 1'b0);
                pop_one();
                chk($sformatf("vec%0d_popped", i), 32'(event_valid), 32'd0);
            end else begin
                tick();
            end
            chk($sformatf("vec%0d_pulse_end", i), 32'({bat_ok, error}), 32'd0);
            tick();
        end

        // Make code with the consumer always ready: exactly one cycle of valid.
        event_ready = 1'b1;
        strobe(8'h1C);
        chk_head("ready_1c", 8'h1C, 1'b0, 1'b0);
        tick();
        chk("ready_1c_gone", 32'(event_valid), 32'd0);
        event_ready = 1'b0;
        tick();

        strobe(8'hF0);
        chk("f0_no_event", 32'(event_valid), 32'd0);
        tick();
        strobe(8'h1C);
        chk_head("brk_1c", 8'h1C, 1'b0, 1'b1);
        pop_one();
        strobe(8'hE0);
        tick();
        strobe(8'hF0);
        chk("e0f0_no_event", 32'(event_valid), 32'd0);
        tick();
        strobe(8'h75);
        chk_head("ext_brk_75", 8'h75, 1'b1, 1'b1);
        pop_one();
        chk("ext_brk_popped", 32'(event_valid), 32'd0);

        for (int i = 0; i < 8; i++) begin
            strobe(pause_seq[i]);
            if (i < 7) chk($sformatf("pause_byte%0d_quiet", i), 32'(event_valid), 32'd0);
            tick();
        end
        chk_head("pause_evt", 8'hE1, 1'b0, 1'b0);
        pop_one();
        chk("pause_single", 32'(event_valid), 32'd0);

        // Timeout after a lone E0.
        strobe(8'hE0);
        k = 0;
        while (!error && k < TMO + 10) begin
            tick();
            k++;
        end
        chk("tmo_latency", 32'(k), 32'(TMO));
        chk("tmo_no_event", 32'(event_valid), 32'd0);
        tick();
        chk("tmo_pulse_end", 32'(error), 32'd0);
        strobe(8'h1C);
        chk_head("after_tmo_1c", 8'h1C, 1'b0, 1'b0);
        pop_one();

        // Overflow: DEPTH+1 make codes with no consumer.
        for (int i = 1; i <= DEPTH + 1; i++) begin
            strobe(8'(i));
            tick();
        end
        chk("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            chk_head($sformatf("drain%0d", i), 8'(i), 1'b0, 1'b0);
            pop_one();
        end
        chk("drain_empty", 32'(event_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of an E0 prefix with two events queued.
        strobe(8'h11);
        tick();
        strobe(8'h22);
        tick();
        strobe(8'hE0);
        tick();
        do_reset();
        chk("midrst_valid", 32'(event_valid), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        chk("midrst_code", 32'(event_code), 32'd0);
        strobe(8'h1C);
        chk_head("midrst_1c", 8'h1C, 1'b0, 1'b0);
        pop_one();

        // Random byte stream against the reference model.
        do_reset();
        model_clear();
        gap = 3;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            chk("rnd_valid", 32'(event_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                chk("rnd_code", 32'(event_code), 32'(exp_q[0][7:0]));
                chk("rnd_ext", 32'(event_extended), 32'(exp_q[0][9]));
                chk("rnd_rel", 32'(event_release), 32'(exp_q[0][8]));
            end
            chk("rnd_bat", 32'(bat_ok), 32'(m_bat));
            chk("rnd_err", 32'(error), 32'(m_err));
            chk("rnd_ovf", 32'(overflow), 32'(m_ovf));

            if ((cyc / 400) % 2 == 1) rdy = ($urandom_range(0, 7) == 0);
            else rdy = ($urandom_range(0, 3) != 0);
            b = 8'h00;
            if (gap == 0) begin
                rxv = 1;
                if ($urandom_range(0, 1) == 1) b = pool[$urandom_range(0, 11)];
                else b = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 7) == 0) gap = $urandom_range(TMO - 2, TMO + 15);
                else gap = $urandom_range(1, 8);
            end else begin
                rxv = 0;
                gap--;
            end
            event_ready = rdy;
            rx_valid    = rxv;
            rx_data     = b;
            model_edge(rdy, rxv, b);
            tick();
        end
        rx_valid    = 1'b0;
        event_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
